fp2dec_conv_arbiter: RTL and testbench

Sequencer and two-port arbiter for the shared combinational IEEE-754 single-precision to decimal converter (`COVERT_BI_2_DEC`). It accepts 32-bit float words from two requesters over valid/ready handshakes and grants them round-robin. It drives the converter input from a stable register, waits a programmable settle time across the deep combinational path, then returns the captured floor, fraction and sign with the requester ID. It sits between the float producers and the decimal display/formatting logic.

---
 rtl/fp2dec_conv_arbiter_if.sv | 37 +++
 rtl/fp2dec_conv_arbiter.sv | 154 +++++++++++++++
 tb/tb_fp2dec_conv_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp2dec_conv_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fp2dec_conv_arbiter_if
// Purpose  : Request (two float producers) and response handshake bundle
//            for the shared float-to-decimal converter sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface fp2dec_conv_arbiter_if;
  logic         req0_valid;
  logic [31:0]  req0_data;
  logic         req0_ready;
  logic         req1_valid;
  logic [31:0]  req1_data;
  logic         req1_ready;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [127:0] rsp_floor;
  logic [127:0] rsp_frac;
  logic         rsp_sign;
  logic         rsp_special;

  // Arbiter side: consumes requests, produces responses.
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_floor, rsp_frac,
           rsp_sign, rsp_special
  );

  // Producer/consumer side.
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_floor, rsp_frac,
           rsp_sign, rsp_special
  );
endinterface
`default_nettype wire

// File: rtl/fp2dec_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp2dec_conv_arbiter
// Purpose  : Round-robin two-port front end for the combinational
//            IEEE-754 single to decimal converter. Holds the converter input
//            in a register, waits SETTLE cycles, captures the result and
//            returns it with the owning requester ID.
// Revision : 1.0 - initial release
// ============================================================================
module fp2dec_conv_arbiter #(
  parameter int SETTLE = 2  // legal range 1..15
) (
  input  wire logic           clk,
  input  wire logic           rst,
  fp2dec_conv_arbiter_if.slave bus,
  output logic [31:0]         conv_in,
  input  wire logic [127:0]   conv_floor,
  input  wire logic [127:0]   conv_frac,
  input  wire logic           conv_sign,
  output logic                busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [3:0]   cnt;
  logic         last_id;

  logic         resp_valid;
  logic         resp_id;
  logic [127:0] resp_floor;
  logic [127:0] resp_frac;
  logic         resp_sign;
  logic         resp_special;

  logic         grant_id;
  logic         accept;
  logic [31:0]  grant_data;
  logic         grant_special;

  // Round-robin grant: a lone requester wins, a tie goes to whoever was not served last.
  always_comb begin
    grant_id = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_id;
    end else begin
      grant_id = bus.req1_valid;
    end
    accept        = (state == ST_IDLE) && !rst && (bus.req0_valid || bus.req1_valid);
    grant_data    = grant_id ? bus.req1_data : bus.req0_data;
    grant_special = &grant_data[30:23];
  end

  assign bus.req0_ready  = accept && !grant_id;
  assign bus.req1_ready  = accept && grant_id;
  assign bus.rsp_valid   = resp_valid;
  assign bus.rsp_id      = resp_id;
  assign bus.rsp_floor   = resp_floor;
  assign bus.rsp_frac    = resp_frac;
  assign bus.rsp_sign    = resp_sign;
  assign bus.rsp_special = resp_special;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: Inf/NaN skip the settle wait; RESP is left only on the consumer handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = grant_special ? ST_RESP : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_valid && bus.rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: converter input latch, settle counter and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_in      <= 32'd0;
      cnt          <= 4'd0;
      last_id      <= 1'b1;
      busy         <= 1'b0;
      resp_valid   <= 1'b0;
      resp_id      <= 1'b0;
      resp_floor   <= 128'd0;
      resp_frac    <= 128'd0;
      resp_sign    <= 1'b0;
      resp_special <= 1'b0;
    end else begin
      busy <= (state_nxt != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            conv_in <= grant_data;
            resp_id <= grant_id;
            last_id <= grant_id;
            if (grant_special) begin
              resp_special <= 1'b1;
              resp_floor   <= 128'd0;
              resp_frac    <= 128'd0;
              resp_sign    <= grant_data[31];
              resp_valid   <= 1'b1;
            end else begin
              cnt <= 4'(SETTLE - 1);
            end
          end
        end
        ST_SETTLE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            resp_floor   <= conv_floor;
            resp_frac    <= conv_frac;
            resp_sign    <= conv_sign;
            resp_special <= 1'b0;
            resp_valid   <= 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_valid && bus.rsp_ready) begin
            resp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp2dec_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp2dec_conv_arbiter
// Purpose  : Directed-vector bench for fp2dec_conv_arbiter with a scoreboard
//            fed at accept time and drained by a response monitor. The
//            converter is a lookup stub of hand-computed decimal results that
//            presents garbage until its input has been stable long enough.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp2dec_conv_arbiter;
  localparam int SETTLE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp2dec_conv_arbiter_if bus();
  logic [31:0]  conv_in;
  logic [127:0] conv_floor;
  logic [127:0] conv_frac;
  logic         conv_sign;
  logic         busy;

  fp2dec_conv_arbiter #(.SETTLE(SETTLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .conv_in    (conv_in),
    .conv_floor (conv_floor),
    .conv_frac  (conv_frac),
    .conv_sign  (conv_sign),
    .busy       (busy)
  );

  typedef struct packed {
    logic         id;
    logic [127:0] floor;
    logic [127:0] frac;
    logic         sign;
    logic         special;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] cur_data = 32'd0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Hand-computed decimal results (BCD: floor right-aligned, fraction left-aligned).
  function automatic void conv_model(input logic [31:0] d, output logic [127:0] fl,
                                     output logic [127:0] fr, output logic sg, output logic kn);
    kn = 1'b1;
    sg = d[31];
    fl = 128'd0;
    fr = 128'd0;
    case (d)
      32'h40000000: fl = 128'h2;                                       // 2.0
      32'h40400000: fl = 128'h3;                                       // 3.0
      32'h40666666: begin                                              // 3.599999904632568359375
        fl = 128'h3;
        fr = 128'h59999990_46325683_59375000_00000000;
      end
      32'h42C86666: begin                                              // 100.1999969482421875
        fl = 128'h100;
        fr = 128'h19999694_82421875_00000000_00000000;
      end
      32'h3E4CCCCD: fr = 128'h20000000_29802322_38769531_25000000;    // 0.20000000298023223876953125
      default: kn = 1'b0;
    endcase
  endfunction

  function automatic exp_t make_exp(input logic id, input logic [31:0] d);
    exp_t x;
    logic kn;
    x.id = id;
    if (&d[30:23]) begin
      x.floor   = 128'd0;
      x.frac    = 128'd0;
      x.sign    = d[31];
      x.special = 1'b1;
    end else begin
      conv_model(d, x.floor, x.frac, x.sign, kn);
      x.special = 1'b0;
    end
    return x;
  endfunction

  // Converter stub: output is only meaningful once conv_in has been stable SETTLE-1 cycles.
  int           age = 0;
  logic [31:0]  prev_in = 32'd0;
  logic [127:0] m_fl;
  logic [127:0] m_fr;
  logic         m_sg;
  logic         m_kn;

  always @(negedge clk) begin
    if (conv_in !== prev_in) age = 0;
    else if (age < 1000) age = age + 1;
    prev_in = conv_in;
  end

  always_comb begin
    m_fl = 128'd0;
    m_fr = 128'd0;
    m_sg = 1'b0;
    m_kn = 1'b0;
    conv_model(conv_in, m_fl, m_fr, m_sg, m_kn);
    if (m_kn && age >= SETTLE - 1) begin
      conv_floor = m_fl;
      conv_frac  = m_fr;
      conv_sign  = m_sg;
    end else begin
      conv_floor = {4{32'hDEADBEEF}};
      conv_frac  = {4{32'hBADC0DE5}};
      conv_sign  = ~m_sg;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard push on accept, pop/compare on response handshake, conv_in stability while busy.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got id %0d want no response", bus.rsp_id);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", bus.rsp_id, e.id);
          chk("rsp_floor", bus.rsp_floor, e.floor);
          chk("rsp_frac", bus.rsp_frac, e.frac);
          chk("rsp_sign", bus.rsp_sign, e.sign);
          chk("rsp_special", bus.rsp_special, e.special);
        end
      end
      if (busy) chk("conv_in_stable", conv_in, cur_data);
      if (bus.req0_valid && bus.req0_ready) begin
        sb.push_back(make_exp(1'b0, bus.req0_data));
        cur_data = bus.req0_data;
      end
      if (bus.req1_valid && bus.req1_ready) begin
        sb.push_back(make_exp(1'b1, bus.req1_data));
        cur_data = bus.req1_data;
      end
    end
  end

  // Wait for the given port's ready, then return just after the accept edge.
  task automatic wait_ready(input int port, input string name);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if ((port == 0 && bus.req0_ready) || (port == 1 && bus.req1_ready)) break;
      n++;
      if (n > 50) begin
        total++;
        bad++;
        $display("FAIL %s: got ready=0 want ready=1 within 50 cycles", name);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Edges after the accept edge until rsp_valid is seen; returns at a negedge.
  task automatic rsp_latency(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid) break;
      lat++;
      if (lat > 40) break;
      @(posedge clk);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy && !bus.rsp_valid) break;
      n++;
      if (n > 60) begin
        total++;
        bad++;
        $display("FAIL wait_idle: got busy=%0d want 0 within 60 cycles", busy);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int prev_t;
    int id;
    int t;

    // Reset with both requesters already valid.
    bus.req0_valid = 1'b1;
    bus.req0_data  = 32'h40000000;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 32'h7F800000;
    bus.rsp_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req0_ready", bus.req0_ready, 1'b0);
    chk("rst_req1_ready", bus.req1_ready, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_id", bus.rsp_id, 1'b0);
    chk("rst_rsp_floor", bus.rsp_floor, 128'd0);
    chk("rst_rsp_frac", bus.rsp_frac, 128'd0);
    chk("rst_rsp_sign", bus.rsp_sign, 1'b0);
    chk("rst_rsp_special", bus.rsp_special, 1'b0);
    chk("rst_conv_in", conv_in, 32'd0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req0_ready", bus.req0_ready, 1'b1);
    chk("post_rst_req1_ready", bus.req1_ready, 1'b0);

    // Single conversion of 2.0 from requester 0 (accepted on the next edge).
    @(posedge clk);
    #1 bus.req0_valid = 1'b0;
    rsp_latency(lat);
    chk("lat_normal", lat, SETTLE);
    chk("single_conv_in", conv_in, 32'h40000000);
    chk("single_busy", busy, 1'b1);

    // Special path: +Inf then NaN from requester 1.
    wait_ready(1, "inf_ready");
    bus.req1_data = 32'hFFC00000;
    rsp_latency(lat);
    chk("lat_special_inf", lat, 0);
    wait_ready(1, "nan_ready");
    bus.req1_valid = 1'b0;
    rsp_latency(lat);
    chk("lat_special_nan", lat, 0);

    // Contention: both stream, grants must alternate with SETTLE+2 spacing.
    wait_idle();
    bus.req0_data  = 32'h40666666;
    bus.req1_data  = 32'h42C86666;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    prev_t = 0;
    for (int n = 0; n < 6; n++) begin
      id = -1;
      for (int w = 0; w < 50; w++) begin
        @(negedge clk);
        if (bus.req0_ready) begin id = 0; break; end
        if (bus.req1_ready) begin id = 1; break; end
      end
      t = cyc;
      chk("cont_id", id, n % 2);
      if (n > 0) chk("cont_spacing", t - prev_t, SETTLE + 2);
      prev_t = t;
      @(posedge clk);
      #1;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Backpressure: 0.2 held for 10 cycles with requester 1 waiting.
    wait_idle();
    bus.rsp_ready  = 1'b0;
    bus.req0_data  = 32'h3E4CCCCD;
    bus.req0_valid = 1'b1;
    wait_ready(0, "bp_ready");
    bus.req0_valid = 1'b0;
    bus.req1_data  = 32'h40000000;
    bus.req1_valid = 1'b1;
    rsp_latency(lat);
    chk("lat_bp", lat, SETTLE);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_rsp_valid", bus.rsp_valid, 1'b1);
      chk("bp_rsp_frac", bus.rsp_frac, 128'h20000000_29802322_38769531_25000000);
      chk("bp_rsp_floor", bus.rsp_floor, 128'd0);
      chk("bp_conv_in", conv_in, 32'h3E4CCCCD);
      chk("bp_req0_ready", bus.req0_ready, 1'b0);
      chk("bp_req1_ready", bus.req1_ready, 1'b0);
      chk("bp_busy", busy, 1'b1);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", bus.rsp_valid, 1'b1);
    @(negedge clk);
    chk("bp_retired_valid", bus.rsp_valid, 1'b0);
    chk("bp_retired_busy", busy, 1'b0);
    chk("bp_idle_req1_ready", bus.req1_ready, 1'b1);
    @(posedge clk);
    #1 bus.req1_valid = 1'b0;

    // Reset during SETTLE drops the in-flight 3.0 and restores the tie-break.
    wait_idle();
    bus.req0_data  = 32'h40400000;
    bus.req0_valid = 1'b1;
    wait_ready(0, "ms_ready");
    bus.req0_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("ms_no_rsp", bus.rsp_valid, 1'b0);
    end
    chk("ms_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    bus.req1_data  = 32'h42C86666;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(negedge clk);
    chk("ms_tie_req0_ready", bus.req0_ready, 1'b1);
    chk("ms_tie_req1_ready", bus.req1_ready, 1'b0);
    @(posedge clk);
    #1 bus.req0_valid = 1'b0;
    wait_ready(1, "ms_req1_ready");
    bus.req1_valid = 1'b0;

    wait_idle();
    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
